mdu_ctrl: RTL and testbench
===========================

# mdu_ctrl

Sequencing controller for the HI/LO multiply/divide unit, generalised from the single-cycle busy/start handshake to parametrised, non-blocking operation with a latency counter. It sits beside the main decoder in the CPU datapath. It decodes mult/multu/div/divu/mfhi/mflo/mthi/mtlo from the instruction fields and launches the shared multiplier or divider. It tracks the operation in flight, stalls the PC only on a HI/LO hazard, and generates the HI/LO write enables and source selects when the result is due.

## Interface
- MUL_LAT, default 4: cycles from start_mul to a valid multiplier result; must be ≥1.
- DIV_LAT, default 33: cycles from start_div to a valid divider result; must be ≥1.
- clk  in  1  system clock; all state updates on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- valid  in  1  the instruction on op/func is live in decode this cycle.
- op  in  6  instruction opcode.
- func  in  6  R-type function field.
- pc_ena  out  1  0 means hold PC and decode (hazard stall).
- start_mul  out  1  one-cycle launch pulse to the multiplier.
- start_div  out  1  one-cycle launch pulse to the divider.
- signed_op  out  1  launched op is signed (mult/div); valid with start_*.
- ena_hi  out  1  HI write enable.
- ena_lo  out  1  LO write enable.
- hi_c  out  2  HI source select: 00 rs, 01 multiplier, 10 divider.
- lo_c  out  2  LO source select, same encoding as hi_c.
- busy  out  1  an operation is in flight (state ≠ IDLE).

## Operation
- Decode is qualified by valid and r_type (op==0):
  - func 011000 is mult, 011001 multu, 011010 div, 011011 divu.
  - func 010000 is mfhi, 010010 mflo, 010001 mthi, 010011 mtlo.
  - is_md = mult|multu|div|divu; is_hl = mfhi|mflo|mthi|mtlo.
- States are IDLE, MUL and DIV. A down-counter cnt has width clog2(max(MUL_LAT,DIV_LAT)+1).
- In IDLE:
  - mult/multu: start_mul=1, go to MUL with cnt=MUL_LAT-1.
  - div/divu: start_div=1, go to DIV with cnt=DIV_LAT-1.
  - signed_op=mult|div.
  - mthi: ena_hi=1, hi_c=00. mtlo: ena_lo=1, lo_c=00. Both are same-cycle and do not stall.
  - mfhi/mflo: no action; the datapath reads HI/LO directly.
- In MUL or DIV:
  - While cnt≠0, cnt decrements each cycle.
  - When cnt==0 (completion cycle): ena_hi=ena_lo=1; hi_c=lo_c=01 (MUL) or 10 (DIV); next state is IDLE.
- Hazard: pc_ena=0 when valid & (is_md|is_hl) & state≠IDLE. This includes the completion cycle.
  - The stalled instruction re-presents and is accepted in the first IDLE cycle.
  - No start pulse and no mthi/mtlo write is issued while stalled.
- Non-HI/LO instructions never stall. They proceed while the unit is busy.
- Outputs are combinational from state, cnt and the decode. Defaults: pc_ena=1, all others 0, hi_c=lo_c=00.

## Timing
- Reset (resetn=0, asynchronous): state=IDLE, cnt=0, busy=0.
  - With no HI/LO instruction presented: start_mul=start_div=0, ena_hi=ena_lo=0, pc_ena=1.
- Deasserting resetn mid-operation abandons the in-flight op. No HI/LO write follows.
- A mult accepted in cycle t:
  - start_mul is high in cycle t; busy is high from t+1.
  - The completion cycle (ena_hi/lo high) is t+MUL_LAT; HI/LO is written at the end of t+MUL_LAT.
  - busy falls at t+MUL_LAT+1.
- A div follows the same pattern with DIV_LAT.
- MUL_LAT=1: the completion cycle is t+1, immediately after the launch.
- A dependent mfhi presented at t+1 is stalled through t+MUL_LAT and accepted at t+MUL_LAT+1. It reads the new value because the register write has happened.
- Back-to-back mult/div: the second stalls until IDLE. Worst-case issue spacing is LAT+1 cycles.
- valid=0 suppresses all decode effects, but the counter and completion proceed.
- A start pulse and a completion never coincide. Start occurs only in IDLE; completion occurs only in MUL/DIV.

## Test plan
- Reset: hold resetn=0 with op=0, func=011000, valid=1 and clk running → busy=0, start_mul=0, ena_hi=ena_lo=0, cnt=0.
  - Then resetn=1 with the same inputs → start_mul=1, pc_ena=1 in that cycle, busy=1 next cycle.
- mult at t=0 with defaults, then NOPs → busy high in t=1..4; ena_hi=ena_lo=1 and hi_c=lo_c=01 only at t=4; busy=0 at t=5.
- divu at t=0, then mflo at t=1 → pc_ena=0 in t=1..33; ena_lo=1 with lo_c=10 at t=33; pc_ena=1 at t=34.
- mult at t=0, then add at t=1 and mthi at t=2 → add has pc_ena=1; mthi has pc_ena=0 in t=2..4 and ena_hi=1 with hi_c=00 at t=5.
- multu at t=0, then div at t=1 → start_div=0 and pc_ena=0 in t=1..4; start_div=1, signed_op=1 at t=5; completion at t=38.
- Async reset at t=2 of a mult (resetn low mid-cycle) → busy=0 immediately; no ena_hi/ena_lo pulse in any later cycle.

Source files
------------

// File: rtl/mdu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mdu_ctrl
//  Purpose  : Sequencing controller for the HI/LO multiply/divide unit.
//             Decodes mult/multu/div/divu/mfhi/mflo/mthi/mtlo, launches the
//             shared multiplier or divider, tracks the operation in flight
//             with a latency down-counter, stalls decode only on a HI/LO
//             hazard, and issues HI/LO write enables and source selects when
//             the result is due.
//  Ports    : clk        - system clock, rising edge
//             resetn     - asynchronous active-low reset
//             valid      - instruction on op/func is live in decode
//             op, func   - opcode / R-type function fields
//             pc_ena     - 0 holds PC and decode (hazard stall)
//             start_mul  - one-cycle multiplier launch pulse
//             start_div  - one-cycle divider launch pulse
//             signed_op  - launched op is signed, valid with start_*
//             ena_hi/lo  - HI/LO write enables
//             hi_c/lo_c  - HI/LO source: 00 rs, 01 multiplier, 10 divider
//             busy       - an operation is in flight
//  Revision : 1.0 - initial release
// ============================================================================
module mdu_ctrl #(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 33
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       valid,
    input  logic [5:0] op,
    input  logic [5:0] func,
    output logic       pc_ena,
    output logic       start_mul,
    output logic       start_div,
    output logic       signed_op,
    output logic       ena_hi,
    output logic       ena_lo,
    output logic [1:0] hi_c,
    output logic [1:0] lo_c,
    output logic       busy
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    localparam logic [CNT_W-1:0] c_MUL_CNT = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] c_DIV_CNT = CNT_W'(DIV_LAT - 1);
    localparam logic [CNT_W-1:0] c_ONE     = CNT_W'(1);

    localparam logic [1:0] c_SRC_RS  = 2'b00;
    localparam logic [1:0] c_SRC_MUL = 2'b01;
    localparam logic [1:0] c_SRC_DIV = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Decode is suppressed while reset is held so that an instruction sitting
    // on the bus cannot launch anything before the unit is out of reset.
    logic w_valid;
    logic w_rtype;
    logic w_mult, w_multu, w_div, w_divu;
    logic w_mfhi, w_mflo, w_mthi, w_mtlo;
    logic w_is_md, w_is_hl;
    logic w_hazard;

    assign w_valid = valid & resetn;
    assign w_rtype = w_valid & (op == 6'b000000);

    assign w_mult  = w_rtype & (func == 6'b011000);
    assign w_multu = w_rtype & (func == 6'b011001);
    assign w_div   = w_rtype & (func == 6'b011010);
    assign w_divu  = w_rtype & (func == 6'b011011);
    assign w_mfhi  = w_rtype & (func == 6'b010000);
    assign w_mflo  = w_rtype & (func == 6'b010010);
    assign w_mthi  = w_rtype & (func == 6'b010001);
    assign w_mtlo  = w_rtype & (func == 6'b010011);

    assign w_is_md = w_mult | w_multu | w_div | w_divu;
    assign w_is_hl = w_mfhi | w_mflo | w_mthi | w_mtlo;

    // Any HI/LO instruction waits while an op is in flight, including the
    // completion cycle, so it is accepted only once HI/LO hold the new value.
    assign w_hazard = (w_is_md | w_is_hl) & (state_q != IDLE);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pc_ena    = ~w_hazard;
        start_mul = 1'b0;
        start_div = 1'b0;
        signed_op = 1'b0;
        ena_hi    = 1'b0;
        ena_lo    = 1'b0;
        hi_c      = c_SRC_RS;
        lo_c      = c_SRC_RS;

        case (state_q)
            IDLE: begin
                if (w_mult | w_multu) begin
                    start_mul = 1'b1;
                    signed_op = w_mult;
                    state_d   = MUL;
                    cnt_d     = c_MUL_CNT;
                end else if (w_div | w_divu) begin
                    start_div = 1'b1;
                    signed_op = w_div;
                    state_d   = DIV;
                    cnt_d     = c_DIV_CNT;
                end
                if (w_mthi) begin
                    ena_hi = 1'b1;
                    hi_c   = c_SRC_RS;
                end
                if (w_mtlo) begin
                    ena_lo = 1'b1;
                    lo_c   = c_SRC_RS;
                end
            end
            MUL, DIV: begin
                if (cnt_q == '0) begin
                    ena_hi  = 1'b1;
                    ena_lo  = 1'b1;
                    hi_c    = (state_q == MUL) ? c_SRC_MUL : c_SRC_DIV;
                    lo_c    = (state_q == MUL) ? c_SRC_MUL : c_SRC_DIV;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - c_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign busy = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mdu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mdu_ctrl
//  Purpose  : Directed self-checking bench for mdu_ctrl with default
//             latencies (MUL_LAT=4, DIV_LAT=33). Inputs change just after the
//             rising edge; outputs are sampled on the falling edge, so the
//             cycle numbered t is the one between rising edges t and t+1.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mdu_ctrl;

    localparam logic [5:0] c_F_MULT  = 6'b011000;
    localparam logic [5:0] c_F_MULTU = 6'b011001;
    localparam logic [5:0] c_F_DIV   = 6'b011010;
    localparam logic [5:0] c_F_DIVU  = 6'b011011;
    localparam logic [5:0] c_F_MFLO  = 6'b010010;
    localparam logic [5:0] c_F_MTHI  = 6'b010001;
    localparam logic [5:0] c_F_ADD   = 6'b100000;

    logic       clk;
    logic       resetn;
    logic       valid;
    logic [5:0] op;
    logic [5:0] func;
    logic       pc_ena;
    logic       start_mul;
    logic       start_div;
    logic       signed_op;
    logic       ena_hi;
    logic       ena_lo;
    logic [1:0] hi_c;
    logic [1:0] lo_c;
    logic       busy;

    int checks = 0;
    int errors = 0;

    mdu_ctrl dut (
        .clk       (clk),
        .resetn    (resetn),
        .valid     (valid),
        .op        (op),
        .func      (func),
        .pc_ena    (pc_ena),
        .start_mul (start_mul),
        .start_div (start_div),
        .signed_op (signed_op),
        .ena_hi    (ena_hi),
        .ena_lo    (ena_lo),
        .hi_c      (hi_c),
        .lo_c      (lo_c),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to the next cycle and present an instruction.
    task automatic next_cycle(input logic v, input logic [5:0] f);
        @(posedge clk);
        #1;
        valid = v;
        op    = 6'd0;
        func  = f;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        resetn = 1'b0;
        valid  = 1'b1;
        op     = 6'd0;
        func   = c_F_MULT;

        // ---------------- reset held with mult presented ----------------
        repeat (3) @(posedge clk);
        sample();
        chk("rst_busy",      busy,       1'b0);
        chk("rst_start_mul", start_mul,  1'b0);
        chk("rst_ena_hi",    ena_hi,     1'b0);
        chk("rst_ena_lo",    ena_lo,     1'b0);
        chk("rst_cnt",       dut.cnt_q,  32'd0);

        // Release reset with the same inputs: mult accepted in this cycle.
        @(posedge clk);
        #1;
        resetn = 1'b1;
        sample();
        chk("rel_start_mul", start_mul, 1'b1);
        chk("rel_pc_ena",    pc_ena,    1'b1);
        chk("rel_signed",    signed_op, 1'b1);
        next_cycle(1'b0, c_F_ADD);
        sample();
        chk("rel_busy_next", busy, 1'b1);
        // Let it drain: now at t=1, completion at t=4, idle at t=5.
        repeat (4) next_cycle(1'b0, c_F_ADD);

        // ---------------- mult, then NOPs ----------------
        next_cycle(1'b1, c_F_MULT);           // t=0
        sample();
        chk("m_t0_start", start_mul, 1'b1);
        chk("m_t0_busy",  busy,      1'b0);
        for (int t = 1; t <= 5; t++) begin
            next_cycle(1'b0, c_F_ADD);
            sample();
            chk($sformatf("m_busy_t%0d", t),   busy,   (t <= 4) ? 1'b1 : 1'b0);
            chk($sformatf("m_enahi_t%0d", t),  ena_hi, (t == 4) ? 1'b1 : 1'b0);
            chk($sformatf("m_enalo_t%0d", t),  ena_lo, (t == 4) ? 1'b1 : 1'b0);
            if (t == 4) begin
                chk("m_hi_c", hi_c, 2'b01);
                chk("m_lo_c", lo_c, 2'b01);
            end
        end

        // ---------------- divu, then dependent mflo ----------------
        next_cycle(1'b1, c_F_DIVU);           // t=0
        sample();
        chk("d_t0_start_div", start_div, 1'b1);
        chk("d_t0_signed",    signed_op, 1'b0);
        for (int t = 1; t <= 34; t++) begin
            next_cycle(1'b1, c_F_MFLO);
            sample();
            chk($sformatf("d_pcena_t%0d", t), pc_ena, (t <= 33) ? 1'b0 : 1'b1);
            chk($sformatf("d_enalo_t%0d", t), ena_lo, (t == 33) ? 1'b1 : 1'b0);
            if (t == 33) chk("d_lo_c", lo_c, 2'b10);
        end

        // ---------------- mult, add, mthi ----------------
        next_cycle(1'b1, c_F_MULT);           // t=0
        next_cycle(1'b1, c_F_ADD);            // t=1
        sample();
        chk("ma_add_pcena", pc_ena, 1'b1);
        for (int t = 2; t <= 5; t++) begin
            next_cycle(1'b1, c_F_MTHI);
            sample();
            chk($sformatf("ma_pcena_t%0d", t), pc_ena, (t <= 4) ? 1'b0 : 1'b1);
            if (t < 4) chk($sformatf("ma_enahi_t%0d", t), ena_hi, 1'b0);
            if (t == 5) begin
                chk("ma_mthi_enahi", ena_hi, 1'b1);
                chk("ma_mthi_hi_c",  hi_c,   2'b00);
                chk("ma_mthi_enalo", ena_lo, 1'b0);
            end
        end

        // ---------------- multu then div back-to-back ----------------
        next_cycle(1'b1, c_F_MULTU);          // t=0
        sample();
        chk("bb_t0_signed", signed_op, 1'b0);
        for (int t = 1; t <= 5; t++) begin
            next_cycle(1'b1, c_F_DIV);
            sample();
            chk($sformatf("bb_startdiv_t%0d", t), start_div, (t == 5) ? 1'b1 : 1'b0);
            chk($sformatf("bb_pcena_t%0d", t),    pc_ena,    (t == 5) ? 1'b1 : 1'b0);
            if (t == 5) chk("bb_signed", signed_op, 1'b1);
        end
        for (int t = 6; t <= 39; t++) begin
            next_cycle(1'b0, c_F_ADD);
            sample();
            chk($sformatf("bb_enahi_t%0d", t), ena_hi, (t == 38) ? 1'b1 : 1'b0);
            if (t == 38) chk("bb_hi_c", hi_c, 2'b10);
            if (t == 39) chk("bb_busy_end", busy, 1'b0);
        end

        // ---------------- async reset in the middle of a mult ----------------
        next_cycle(1'b1, c_F_MULT);           // t=0
        next_cycle(1'b0, c_F_ADD);            // t=1
        next_cycle(1'b0, c_F_ADD);            // t=2
        #2;
        resetn = 1'b0;
        #1;
        chk("ar_busy_now", busy, 1'b0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        for (int t = 0; t < 6; t++) begin
            sample();
            chk($sformatf("ar_enahi_%0d", t), ena_hi, 1'b0);
            chk($sformatf("ar_enalo_%0d", t), ena_lo, 1'b0);
            chk($sformatf("ar_busy_%0d", t),  busy,   1'b0);
            next_cycle(1'b0, c_F_ADD);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
